// File: rtl/serial_frame_tx.sv
// rtl/serial_frame_tx.sv - parallel-in serial-out frame transmitter (start, LSB-first data, even parity, stop)
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic                serial_q, serial_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                bit_end;

    // State, counters, shift register and registered outputs; reset forces the line high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            serial_q <= serial_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state logic; serial_d is the line value for the cycle after the edge, so outputs stay registered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        par_d    = par_q;
        serial_d = serial_q;
        bit_end  = (cnt_q == CNT_LAST);

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                serial_d = 1'b1;
                cnt_d    = '0;
                idx_d    = '0;
                if (tx_valid && ready_q) begin
                    shift_d  = tx_data;
                    par_d    = ^tx_data;
                    state_d  = S_START;
                    serial_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d  = S_DATA;
                    serial_d = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_d  = S_PARITY;
                            serial_d = par_q;
                        end else begin
                            state_d  = S_STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        shift_d  = shift_q >> 1;
                        serial_d = shift_d[0];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d  = S_STOP;
                    serial_d = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d  = S_IDLE;
                    serial_d = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                serial_d = 1'b1;
            end
        endcase

        // Done is raised for exactly the last cycle of the stop bit.
        done_d  = (state_d == S_STOP) && (cnt_d == CNT_LAST);
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    assign tx_serial = serial_q;
    assign tx_done   = done_q;
    assign tx_ready  = ready_q;
    assign tx_busy   = busy_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb/tb_serial_frame_tx.sv - randomized and directed checks of serial_frame_tx against a frame-level model
module tb_serial_frame_tx;

    logic       clk;
    logic       rst;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid;
    logic       a_ready, a_serial, a_busy, a_done;
    logic       b_ready, b_serial, b_busy, b_done;

    int n_cmp;
    int n_err;

    // Default configuration: 8 data bits, 4 clocks per bit, even parity.
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (a_data),
        .tx_valid  (a_valid),
        .tx_ready  (a_ready),
        .tx_serial (a_serial),
        .tx_busy   (a_busy),
        .tx_done   (a_done)
    );

    // Fast configuration: one clock per bit, no parity.
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (b_data),
        .tx_valid  (b_valid),
        .tx_ready  (b_ready),
        .tx_serial (b_serial),
        .tx_busy   (b_busy),
        .tx_done   (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line value of bit slot pos in a frame: start, data LSB first, optional parity, stop.
    function automatic logic exp_bit(input logic [7:0] w, input bit par, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return w[pos-1];
        if (par && pos == 9) return ($countones(w) % 2) == 1;
        return 1'b1;
    endfunction

    function automatic logic [3:0] obs(input bit sel);
        return sel ? {b_serial, b_ready, b_busy, b_done} : {a_serial, a_ready, a_busy, a_done};
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed={ser,rdy,bsy,done}=%b expected=%b", tag, got, exp);
        end
    endtask

    // Called at a negedge with the word presented and valid high; checks every cycle of the frame
    // and the idle cycle after it. hold keeps valid high and swaps in nw right after acceptance.
    task automatic run_frame(input bit sel, input logic [7:0] w, input bit hold, input logic [7:0] nw);
        int  cpb;
        bit  par;
        int  len;
        cpb = sel ? 1 : 4;
        par = !sel;
        len = (par ? 11 : 10) * cpb;
        @(posedge clk);
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (hold) begin
                    if (sel) b_data = nw; else a_data = nw;
                end else begin
                    if (sel) begin b_valid = 1'b0; b_data = 8'($urandom); end
                    else     begin a_valid = 1'b0; a_data = 8'($urandom); end
                end
            end
            chk($sformatf("%s_w%02h_k%0d", sel ? "b" : "a", w, k), obs(sel),
                {exp_bit(w, par, (k - 1) / cpb), 1'b0, 1'b1, (k == len)});
        end
        @(negedge clk);
        chk($sformatf("%s_w%02h_idle", sel ? "b" : "a", w), obs(sel), 4'b1100);
    endtask

    initial begin
        logic [7:0] w;
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        a_data  = 8'h5A;
        b_data  = 8'h5A;

        // Reset held with valid high: nothing may start.
        repeat (3) begin
            @(negedge clk);
            chk("rst_a", obs(0), 4'b1100);
            chk("rst_b", obs(1), 4'b1100);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        chk("post_rst_a", obs(0), 4'b1100);

        // Directed words: even-parity A5, odd-parity 07.
        a_data = 8'hA5; a_valid = 1'b1;
        run_frame(0, 8'hA5, 0, 8'h00);
        a_data = 8'h07; a_valid = 1'b1;
        run_frame(0, 8'h07, 0, 8'h00);

        // Back-to-back with valid held high; second word taken on the single idle cycle.
        a_data = 8'h3C; a_valid = 1'b1;
        run_frame(0, 8'h3C, 1, 8'hC3);
        run_frame(0, 8'hC3, 0, 8'h00);

        // Asynchronous reset during data bit 3, then a clean frame.
        w = 8'($urandom);
        a_data = w; a_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (k == 1) begin a_valid = 1'b0; a_data = 8'($urandom); end
        end
        chk("mid_bit3", obs(0), {w[3], 1'b0, 1'b1, 1'b0});
        #2 rst = 1'b0;
        #1 chk("mid_rst_async", obs(0), 4'b1100);
        @(negedge clk);
        rst = 1'b1;
        w = 8'($urandom);
        a_data = w; a_valid = 1'b1;
        run_frame(0, w, 0, 8'h00);

        // Fast configuration: all-ones word then random words.
        b_data = 8'hFF; b_valid = 1'b1;
        run_frame(1, 8'hFF, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom);
            b_data = w; b_valid = 1'b1;
            run_frame(1, w, 0, 8'h00);
        end

        // Random words on the default configuration, including a held back-to-back pair.
        for (int i = 0; i < 3; i++) begin
            w = 8'($urandom);
            a_data = w; a_valid = 1'b1;
            run_frame(0, w, 0, 8'h00);
        end
        w = 8'($urandom);
        a_data = w; a_valid = 1'b1;
        begin
            logic [7:0] w2;
            w2 = 8'($urandom);
            run_frame(0, w, 1, w2);
            run_frame(0, w2, 0, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
